// File: rtl/axi_slave_mem_responder.sv
// Byte-wide AXI4 slave memory model with independent single-outstanding read and write FSMs.
// Exposes saturating completion counters and a sticky protocol-error flag for verification.
module axi_slave_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 5,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [7:0]            wdata,
    input  logic                  wstrb,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_WIDTH-1:0]   bid,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [7:0]            rdata,
    output logic                  rlast,
    output logic [15:0]           wr_done_o,
    output logic [15:0]           rd_done_o,
    output logic                  err_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    logic [7:0]       mem [MEM_DEPTH];

    logic [1:0]       w_state;
    logic [IDX_W-1:0] w_addr;
    logic [8:0]       w_left;
    logic [1:0]       w_burst;

    logic             r_state;
    logic [IDX_W-1:0] r_addr;
    logic [8:0]       r_left;
    logic [1:0]       r_burst;

    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic             w_last_beat, r_last_beat;
    logic [IDX_W-1:0] w_next, r_next;
    logic             w_err, r_err;
    logic             unused_addr_bits;

    assign awready = (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);
    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    assign w_last_beat = (w_left == 9'd1);
    assign r_last_beat = (r_left == 9'd1);

    // WRAP bursts deliberately advance like INCR; only FIXED holds the address.
    assign w_next = (w_burst == BURST_FIXED) ? w_addr : w_addr + IDX_W'(1);
    assign r_next = (r_burst == BURST_FIXED) ? r_addr : r_addr + IDX_W'(1);

    assign w_err = (aw_hs && ((awsize != 3'd0) || (awburst == BURST_RSVD)))
                || (w_hs && (wlast != w_last_beat));
    assign r_err = ar_hs && ((arsize != 3'd0) || (arburst == BURST_RSVD));

    assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:IDX_W], araddr[ADDR_WIDTH-1:IDX_W]};

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_hs && wstrb)
            mem[w_addr] <= wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_left  <= '0;
            w_burst <= '0;
            bid     <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    bid     <= awid;
                    w_addr  <= awaddr[IDX_W-1:0];
                    w_left  <= {1'b0, awlen} + 9'd1;
                    w_burst <= awburst;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_addr <= w_next;
                    w_left <= w_left - 9'd1;
                    if (w_last_beat)
                        w_state <= W_RESP;
                end
                W_RESP: if (b_hs)
                    w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // rdata is fetched one beat ahead, so it reads the pre-write value on a same-edge collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_left  <= '0;
            r_burst <= '0;
            rid     <= '0;
            rdata   <= '0;
            rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    rid     <= arid;
                    r_addr  <= araddr[IDX_W-1:0];
                    r_left  <= {1'b0, arlen} + 9'd1;
                    r_burst <= arburst;
                    rdata   <= mem[araddr[IDX_W-1:0]];
                    rlast   <= (arlen == 8'd0);
                    r_state <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    if (r_last_beat) begin
                        rlast   <= 1'b0;
                        r_state <= R_IDLE;
                    end else begin
                        r_addr <= r_next;
                        r_left <= r_left - 9'd1;
                        rdata  <= mem[r_next];
                        rlast  <= (r_left == 9'd2);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_done_o <= '0;
            rd_done_o <= '0;
            err_o     <= 1'b0;
        end else begin
            if (b_hs && (wr_done_o != 16'hFFFF))
                wr_done_o <= wr_done_o + 16'd1;
            if (r_hs && rlast && (rd_done_o != 16'hFFFF))
                rd_done_o <= rd_done_o + 16'd1;
            if (w_err || r_err)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed bench for axi_slave_mem_responder: hand-computed vectors for write/read,
// bursts with index wrap, FIXED + strobe, backpressure, protocol errors and reset mid-burst.
module tb_axi_slave_mem_responder;

    localparam int ADDR_WIDTH = 16;
    localparam int ID_WIDTH   = 5;
    localparam int MEM_DEPTH  = 256;
    localparam int TIMEOUT    = 20;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  awvalid, awready;
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid, wready;
    logic [7:0]            wdata;
    logic                  wstrb, wlast;
    logic                  bvalid, bready;
    logic [ID_WIDTH-1:0]   bid;
    logic                  arvalid, arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid, rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [7:0]            rdata;
    logic                  rlast;
    logic [15:0]           wr_done_o, rd_done_o;
    logic                  err_o;

    int vectors = 0;
    int misses  = 0;

    always #5 clk_i = ~clk_i;

    axi_slave_mem_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .awvalid  (awvalid),
        .awready  (awready),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .bvalid   (bvalid),
        .bready   (bready),
        .bid      (bid),
        .arvalid  (arvalid),
        .arready  (arready),
        .arid     (arid),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .rvalid   (rvalid),
        .rready   (rready),
        .rid      (rid),
        .rdata    (rdata),
        .rlast    (rlast),
        .wr_done_o(wr_done_o),
        .rd_done_o(rd_done_o),
        .err_o    (err_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic resetDut();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic sendAw(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size;
        awvalid = 1'b1;
        while (!awready && n < TIMEOUT) begin tick(); n++; end
        if (n == TIMEOUT) checkOutput("aw_ready_timeout", {31'b0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic sendW(input logic [7:0] data, input logic strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last;
        wvalid = 1'b1;
        while (!wready && n < TIMEOUT) begin tick(); n++; end
        if (n == TIMEOUT) checkOutput("w_ready_timeout", {31'b0, wready}, 32'd1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic ackB();
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < TIMEOUT) begin tick(); n++; end
        if (n == TIMEOUT) checkOutput("b_valid_timeout", {31'b0, bvalid}, 32'd1);
        tick();
        bready = 1'b0;
    endtask

    task automatic sendAr(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size;
        arvalid = 1'b1;
        while (!arready && n < TIMEOUT) begin tick(); n++; end
        if (n == TIMEOUT) checkOutput("ar_ready_timeout", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic recvR(input string tag, input logic [7:0] exp_data, input logic exp_last,
                         input logic [4:0] exp_id);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < TIMEOUT) begin tick(); n++; end
        checkOutput({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        checkOutput({tag, "_rdata"}, {24'b0, rdata}, {24'b0, exp_data});
        checkOutput({tag, "_rlast"}, {31'b0, rlast}, {31'b0, exp_last});
        checkOutput({tag, "_rid"}, {27'b0, rid}, {27'b0, exp_id});
        tick();
        rready = 1'b0;
    endtask

    task automatic applyStimulus();
        // Reset values
        resetDut();
        checkOutput("rst_awready", {31'b0, awready}, 32'd1);
        checkOutput("rst_arready", {31'b0, arready}, 32'd1);
        checkOutput("rst_wready",  {31'b0, wready},  32'd0);
        checkOutput("rst_bvalid",  {31'b0, bvalid},  32'd0);
        checkOutput("rst_rvalid",  {31'b0, rvalid},  32'd0);
        checkOutput("rst_rlast",   {31'b0, rlast},   32'd0);
        checkOutput("rst_ids",     {22'b0, bid, rid}, 32'd0);
        checkOutput("rst_rdata",   {24'b0, rdata},   32'd0);
        checkOutput("rst_counts",  {wr_done_o, rd_done_o}, 32'd0);
        checkOutput("rst_err",     {31'b0, err_o},   32'd0);

        // Single write then read
        sendAw(5'd1, 16'h0010, 8'd0, INCR, 3'd0);
        sendW(8'hA5, 1'b1, 1'b1);
        checkOutput("w1_bvalid", {31'b0, bvalid}, 32'd1);
        checkOutput("w1_bid", {27'b0, bid}, 32'd1);
        checkOutput("w1_wr_done_pre", {16'b0, wr_done_o}, 32'd0);
        ackB();
        checkOutput("w1_wr_done", {16'b0, wr_done_o}, 32'd1);
        checkOutput("w1_awready", {31'b0, awready}, 32'd1);
        sendAr(5'd1, 16'h0010, 8'd0, INCR, 3'd0);
        recvR("r1", 8'hA5, 1'b1, 5'd1);
        checkOutput("r1_rd_done", {16'b0, rd_done_o}, 32'd1);

        // INCR burst wrapping the memory index
        sendAw(5'd2, 16'h00FE, 8'd3, INCR, 3'd0);
        sendW(8'h11, 1'b1, 1'b0);
        sendW(8'h22, 1'b1, 1'b0);
        sendW(8'h33, 1'b1, 1'b0);
        sendW(8'h44, 1'b1, 1'b1);
        ackB();
        sendAr(5'd2, 16'h00FE, 8'd3, INCR, 3'd0);
        recvR("r2b0", 8'h11, 1'b0, 5'd2);
        recvR("r2b1", 8'h22, 1'b0, 5'd2);
        recvR("r2b2", 8'h33, 1'b0, 5'd2);
        recvR("r2b3", 8'h44, 1'b1, 5'd2);
        checkOutput("r2_rd_done", {16'b0, rd_done_o}, 32'd2);

        // FIXED burst with strobe: only beats 1 and 3 land, on the same byte
        sendAw(5'd5, 16'h0020, 8'd2, FIXED, 3'd0);
        sendW(8'h01, 1'b1, 1'b0);
        sendW(8'h02, 1'b0, 1'b0);
        sendW(8'h03, 1'b1, 1'b1);
        ackB();
        sendAr(5'd5, 16'h0020, 8'd1, FIXED, 3'd0);
        recvR("r3b0", 8'h03, 1'b0, 5'd5);
        recvR("r3b1", 8'h03, 1'b1, 5'd5);
        checkOutput("r3_rd_done", {16'b0, rd_done_o}, 32'd3);
        checkOutput("r3_err", {31'b0, err_o}, 32'd0);

        // Backpressure on B
        sendAw(5'd7, 16'h0030, 8'd0, INCR, 3'd0);
        sendW(8'h5C, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_bvalid", {31'b0, bvalid}, 32'd1);
            checkOutput("bp_bid", {27'b0, bid}, 32'd7);
            checkOutput("bp_wr_done", {16'b0, wr_done_o}, 32'd3);
            tick();
        end
        ackB();
        checkOutput("bp_wr_done_after", {16'b0, wr_done_o}, 32'd4);

        // Backpressure on R beat 2
        sendAr(5'd6, 16'h00FE, 8'd3, INCR, 3'd0);
        recvR("bpr_b0", 8'h11, 1'b0, 5'd6);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bpr_rvalid", {31'b0, rvalid}, 32'd1);
            checkOutput("bpr_rdata", {24'b0, rdata}, 32'h22);
            checkOutput("bpr_rlast", {31'b0, rlast}, 32'd0);
            checkOutput("bpr_rd_done", {16'b0, rd_done_o}, 32'd3);
            tick();
        end
        recvR("bpr_b1", 8'h22, 1'b0, 5'd6);
        recvR("bpr_b2", 8'h33, 1'b0, 5'd6);
        recvR("bpr_b3", 8'h44, 1'b1, 5'd6);
        checkOutput("bpr_rd_done_after", {16'b0, rd_done_o}, 32'd4);

        // Early wlast on beat 1 of a 3-beat write
        sendAw(5'd3, 16'h0050, 8'd2, INCR, 3'd0);
        sendW(8'h61, 1'b1, 1'b1);
        checkOutput("pe_err_set", {31'b0, err_o}, 32'd1);
        sendW(8'h62, 1'b1, 1'b0);
        checkOutput("pe_no_b_yet", {31'b0, bvalid}, 32'd0);
        sendW(8'h63, 1'b1, 1'b1);
        checkOutput("pe_bvalid", {31'b0, bvalid}, 32'd1);
        ackB();
        checkOutput("pe_wr_done", {16'b0, wr_done_o}, 32'd5);
        checkOutput("pe_bvalid_drop", {31'b0, bvalid}, 32'd0);
        tick();
        checkOutput("pe_err_sticky", {31'b0, err_o}, 32'd1);

        // Reset during beat 2 of an 8-beat read
        sendAr(5'd4, 16'h00FE, 8'd7, INCR, 3'd0);
        recvR("mr_b0", 8'h11, 1'b0, 5'd4);
        checkOutput("mr_b1_rdata", {24'b0, rdata}, 32'h22);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput("mr_rvalid", {31'b0, rvalid}, 32'd0);
        checkOutput("mr_arready", {31'b0, arready}, 32'd1);
        checkOutput("mr_rd_done", {16'b0, rd_done_o}, 32'd0);
        checkOutput("mr_wr_done", {16'b0, wr_done_o}, 32'd0);
        checkOutput("mr_err", {31'b0, err_o}, 32'd0);
        sendAr(5'd1, 16'h0010, 8'd0, INCR, 3'd0);
        recvR("mr_keep", 8'hA5, 1'b1, 5'd1);
        checkOutput("mr_rd_done_after", {16'b0, rd_done_o}, 32'd1);

        // Non-zero arsize flags an error; the read still completes
        sendAr(5'd9, 16'h0100, 8'd0, INCR, 3'd1);
        checkOutput("as_err", {31'b0, err_o}, 32'd1);
        recvR("as_read", 8'h33, 1'b1, 5'd9);
    endtask

    initial begin
        rst_i   = 1'b0;
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid  = 1'b0; wdata = '0; wstrb = 1'b0; wlast = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        rready  = 1'b0;
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem_responder.md
Name: axi_slave_mem_responder

Overview:
- Byte-wide AXI4 slave memory model that sits directly downstream of axi_master_loader and terminates its AW/W/B and AR/R traffic.
- Gives the loader benches and the NoC endpoints a deterministic, self-checking target.
- Read and write channels run independent FSMs, each with one outstanding burst.
- Completed-transaction counters and a sticky protocol-error flag are exposed for verification.

Parameters:
ADDR_WIDTH, 16, AXI address width.
ID_WIDTH, 5, AXI ID width for AW/B and AR/R.
MEM_DEPTH, 256, bytes of storage; must be a power of two; index = addr[$clog2(MEM_DEPTH)-1:0].

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  synchronous reset, active-high.
awvalid/awready  in/out  1/1  AW handshake.
awid, awaddr, awlen, awsize, awburst  in  ID_WIDTH, ADDR_WIDTH, 8, 3, 2  AW payload.
wvalid/wready  in/out  1/1  W handshake.
wdata, wstrb, wlast  in  8, 1, 1  W payload.
bvalid/bready  out/in  1/1  B handshake.
bid  out  ID_WIDTH  B ID.
arvalid/arready  in/out  1/1  AR handshake.
arid, araddr, arlen, arsize, arburst  in  ID_WIDTH, ADDR_WIDTH, 8, 3, 2  AR payload.
rvalid/rready  out/in  1/1  R handshake.
rid, rdata, rlast  out  ID_WIDTH, 8, 1  R payload.
wr_done_o  out  16  count of B handshakes; saturates at 0xFFFF.
rd_done_o  out  16  count of R handshakes with rlast=1; saturates at 0xFFFF.
err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_i=1 at an edge): both FSMs go to IDLE. awready=1, arready=1. wready, bvalid, rvalid, rlast = 0. bid, rid, rdata = 0. Counters and err_o = 0. Memory contents are not touched.
- Reset mid-burst abandons the burst without emitting B or R.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. An AW handshake latches awid, the address, awlen+1 as the beat count and awburst, then moves to W_DATA on the next cycle.
  - W_DATA: wready=1, awready=0. Each W handshake writes wdata to mem[idx] only when wstrb=1.
  - Address update: INCR and WRAP add 1 modulo MEM_DEPTH (WRAP is treated as INCR). FIXED holds the address.
  - The beat counter alone terminates the burst. The last beat moves the FSM to W_RESP.
  - Latency: last W handshake at edge N gives bvalid=1 and bid=latched ID in cycle N+1.
  - W_RESP: bvalid held until bready. The B handshake increments wr_done_o and returns to W_IDLE with awready=1 in the next cycle. Minimum AW-to-AW spacing is awlen+3 cycles.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. An AR handshake latches arid, the address, arlen+1 and arburst, and registers rdata=mem[idx].
  - Latency: rvalid=1 in the cycle after the AR handshake.
  - R_DATA: rvalid=1, rid=latched ID, rlast=1 only on the final beat.
  - On each R handshake that is not the last beat, the address advances using the write-side rules and rdata is re-registered from the new address.
  - rdata, rid and rlast stay stable while rvalid=1 and rready=0.
  - The last R handshake increments rd_done_o and returns to R_IDLE.
- Simultaneous read/write to the same byte at the same edge: the registered rdata captures the old value; the new value is visible to later beats.
- Both FSMs run fully concurrently. A read and a write may be in flight simultaneously.
- err_o is set (sticky until reset) on any of:
  - wlast=1 on a non-final W beat;
  - wlast=0 on the final W beat;
  - awsize≠0 or arsize≠0 on an accepted request;
  - awburst=2'b11 or arburst=2'b11 on an accepted request.
  The transaction still completes normally.
- Width rules: beat count is 9 bits (awlen 255 gives 256 beats). Memory index wraps modulo MEM_DEPTH. Upper address bits are ignored.

Test Plan:
- Single write then read: AW id=1, addr=0x0010, len=0, INCR, W data=0xA5, wlast=1 → bvalid one cycle after W, bid=1, wr_done_o=1. AR id=1, addr=0x0010, len=0 → rvalid next cycle, rdata=0xA5, rlast=1, rd_done_o=1.
- INCR burst with wrap: write len=3 at 0x00FE with data 0x11,0x22,0x33,0x44 → mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33, mem[0x01]=0x44. Read len=3 at 0x00FE returns the same sequence with rlast only on the 4th beat.
- FIXED burst with strobe: write len=2 at 0x0020, data 0x01,0x02,0x03, wstrb 1,0,1 → mem[0x20]=0x03. Read-back returns 0x03.
- Backpressure: hold bready=0 for 5 cycles, and hold rready low on beat 2 of a len=3 read → bvalid/bid and rvalid/rdata/rlast stay stable. Counters increment only on handshake.
- Protocol error: wlast=1 on beat 1 of a len=2 write → err_o=1 in the next cycle. The burst still accepts 3 beats and issues one B. err_o stays 1 until rst_i.
- Reset mid-read: assert rst_i during beat 2 of a len=7 read → next cycle rvalid=0, arready=1, rd_done_o=0, err_o=0. Previously written memory data is still readable.
